// File: rtl/md_unit_if.sv
// md_unit_if: E-stage bundle between the pipeline and the multiply/divide unit.
//   master: pipeline side (drives launch/operands/read select)
//   slave : md_unit side (drives busy, HI/LO and the MFHI/MFLO value)
interface md_unit_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_hi;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdout;

  modport master (
    output start, op, a, b, rd_hi,
    input  busy, hi, lo, mdout
  );

  modport slave (
    input  start, op, a, b, rd_hi,
    output busy, hi, lo, mdout
  );
endinterface

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit with HI/LO ownership and modelled latency.
//   The result is computed in one shot at launch into a 64-bit shadow {sh,sl};
//   busy is then held for MULT_CYCLES / DIV_CYCLES edges and the shadow is
//   committed to HI/LO on the edge that drops busy.
//   Optional feature macro: MD_MADD_EN enables MADD/MADDU/MSUB/MSUBU (ops 7..10).
//   Without it those ops are treated as NONE and no accumulate adder exists.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     rst_n,
  md_unit_if.slave md
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      sh_q, sh_d;
  logic [31:0]      sl_q, sl_d;
  logic             div0_q, div0_d;   // pending op was a divide by zero: skip commit

  // Arithmetic datapath (all combinational from the current operands)
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] dvsr;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] uq_s, ur_s;
  logic [31:0] q_s, r_s;
  logic [31:0] q_u, r_u;
  logic        b_zero;
`ifdef MD_MADD_EN
  logic [63:0] acc_madd, acc_maddu, acc_msub, acc_msubu;
`endif

  // Products, quotients and remainders for every launchable op
  always_comb begin
    // Low 64 bits of the product of sign-extended operands equal the signed product.
    prod_s = {{32{md.a[31]}}, md.a} * {{32{md.b[31]}}, md.b};
    prod_u = {32'd0, md.a} * {32'd0, md.b};
    b_zero = (md.b == 32'd0);
    // Substitute 1 for a zero divisor; the result is discarded anyway.
    dvsr   = b_zero ? 32'd1 : md.b;
    // Signed divide through magnitudes: avoids the -2^31 / -1 overflow and gives
    // truncation toward zero with the remainder taking the dividend's sign.
    abs_a  = md.a[31] ? (32'd0 - md.a) : md.a;
    abs_b  = dvsr[31] ? (32'd0 - dvsr) : dvsr;
    uq_s   = abs_a / abs_b;
    ur_s   = abs_a % abs_b;
    q_s    = (md.a[31] ^ dvsr[31]) ? (32'd0 - uq_s) : uq_s;
    r_s    = md.a[31] ? (32'd0 - ur_s) : ur_s;
    q_u    = md.a / dvsr;
    r_u    = md.a % dvsr;
`ifdef MD_MADD_EN
    acc_madd  = {hi_q, lo_q} + prod_s;
    acc_maddu = {hi_q, lo_q} + prod_u;
    acc_msub  = {hi_q, lo_q} - prod_s;
    acc_msubu = {hi_q, lo_q} - prod_u;
`endif
  end

  // Next-state: launch in IDLE, count down in RUN, commit the shadow on cnt==0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_d    = sh_q;
    sl_d    = sl_q;
    div0_d  = div0_q;
    case (state_q)
      S_IDLE: begin
        if (md.start) begin
          case (md.op)
            OP_MULT: begin
              {sh_d, sl_d} = prod_s;
              div0_d  = 1'b0;
              cnt_d   = MULT_LOAD;
              busy_d  = 1'b1;
              state_d = S_RUN;
            end
            OP_MULTU: begin
              {sh_d, sl_d} = prod_u;
              div0_d  = 1'b0;
              cnt_d   = MULT_LOAD;
              busy_d  = 1'b1;
              state_d = S_RUN;
            end
            OP_DIV: begin
              sl_d    = q_s;
              sh_d    = r_s;
              div0_d  = b_zero;
              cnt_d   = DIV_LOAD;
              busy_d  = 1'b1;
              state_d = S_RUN;
            end
            OP_DIVU: begin
              sl_d    = q_u;
              sh_d    = r_u;
              div0_d  = b_zero;
              cnt_d   = DIV_LOAD;
              busy_d  = 1'b1;
              state_d = S_RUN;
            end
            OP_MTHI: hi_d = md.a;
            OP_MTLO: lo_d = md.a;
`ifdef MD_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              case (md.op)
                OP_MADD:  {sh_d, sl_d} = acc_madd;
                OP_MADDU: {sh_d, sl_d} = acc_maddu;
                OP_MSUB:  {sh_d, sl_d} = acc_msub;
                default:  {sh_d, sl_d} = acc_msubu;
              endcase
              div0_d  = 1'b0;
              cnt_d   = MULT_LOAD;
              busy_d  = 1'b1;
              state_d = S_RUN;
            end
`endif
            default: ;  // NONE, unused encodings: no effect
          endcase
        end
      end
      S_RUN: begin
        // Any start seen here is ignored: the pipeline never issues one.
        if (cnt_q == '0) begin
          if (!div0_q) begin
            hi_d = sh_q;
            lo_d = sl_q;
          end
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any in-flight op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      sh_q    <= 32'd0;
      sl_q    <= 32'd0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_q    <= sh_d;
      sl_q    <= sl_d;
      div0_q  <= div0_d;
    end
  end

  assign md.busy  = busy_q;
  assign md.hi    = hi_q;
  assign md.lo    = lo_q;
  assign md.mdout = md.rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit (default 5/10 cycle latencies).
// Define MD_MADD_EN for both RTL and bench to exercise the accumulate ops.
module tb_md_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   n;

  md_unit_if md_if ();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (md_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a wait is never satisfied
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Present an op for exactly one edge
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    md_if.start = 1'b1;
    md_if.op    = op;
    md_if.a     = a;
    md_if.b     = b;
    step();
    md_if.start = 1'b0;
    md_if.op    = 4'd0;
    $display("issue op=%0d a=%08h b=%08h", op, a, b);
  endtask

  // Count samples with busy high, bounded
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (md_if.busy === 1'b1 && cnt < 40) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    md_if.start = 1'b0;
    md_if.op    = 4'd0;
    md_if.a     = 32'd0;
    md_if.b     = 32'd0;
    md_if.rd_hi = 1'b0;
    step();
    step();
    chk("rst_busy", {31'd0, md_if.busy}, 32'd0);
    chk("rst_hi", md_if.hi, 32'd0);
    chk("rst_lo", md_if.lo, 32'd0);
    chk("rst_mdout", md_if.mdout, 32'd0);
    rst_n = 1'b1;
    step();

    // MULT 3 * -2 = -6
    issue(4'd1, 32'd3, 32'hFFFF_FFFE);
    chk("mult_old_hi", md_if.hi, 32'd0);
    count_busy(n);
    chk("mult_busy_cycles", 32'(n), 32'd5);
    chk("mult_hi", md_if.hi, 32'hFFFF_FFFF);
    chk("mult_lo", md_if.lo, 32'hFFFF_FFFA);

    // DIVU 7 / 2
    issue(4'd4, 32'd7, 32'd2);
    count_busy(n);
    chk("divu_busy_cycles", 32'(n), 32'd10);
    chk("divu_lo", md_if.lo, 32'd3);
    chk("divu_hi", md_if.hi, 32'd1);

    // DIV -7 / 2 = -3 rem -1
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    chk("div_neg_busy", 32'(n), 32'd10);
    chk("div_neg_lo", md_if.lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", md_if.hi, 32'hFFFF_FFFF);

    // DIV overflow corner
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    chk("div_ovf_lo", md_if.lo, 32'h8000_0000);
    chk("div_ovf_hi", md_if.hi, 32'd0);

    // MTHI / MTLO then divide by zero
    issue(4'd5, 32'h1234, 32'd0);
    chk("mthi_hi", md_if.hi, 32'h1234);
    chk("mthi_busy", {31'd0, md_if.busy}, 32'd0);
    issue(4'd6, 32'h5678, 32'd0);
    chk("mtlo_lo", md_if.lo, 32'h5678);
    chk("mtlo_busy", {31'd0, md_if.busy}, 32'd0);
    issue(4'd3, 32'd5, 32'd0);
    count_busy(n);
    chk("div0_busy_cycles", 32'(n), 32'd10);
    chk("div0_hi", md_if.hi, 32'h1234);
    chk("div0_lo", md_if.lo, 32'h5678);
    md_if.rd_hi = 1'b1;
    #1;
    chk("mdout_hi", md_if.mdout, 32'h1234);
    md_if.rd_hi = 1'b0;
    #1;
    chk("mdout_lo", md_if.mdout, 32'h5678);

    // MULT with a DIVU presented mid-flight: the DIVU must be ignored
    issue(4'd1, 32'd6, 32'd7);
    step();
    issue(4'd4, 32'd100, 32'd3);
    count_busy(n);
    chk("mult_ign_busy_cycles", 32'(n + 2), 32'd5);
    chk("mult_ign_hi", md_if.hi, 32'd0);
    chk("mult_ign_lo", md_if.lo, 32'd42);
    step();
    chk("mult_ign_no_restart", {31'd0, md_if.busy}, 32'd0);
    chk("mult_ign_lo_kept", md_if.lo, 32'd42);

    // DIV aborted by asynchronous reset in its 4th busy cycle
    issue(4'd3, 32'd100, 32'd7);
    step();
    step();
    step();
    chk("div_abort_busy_pre", {31'd0, md_if.busy}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, md_if.busy}, 32'd0);
    chk("abort_hi", md_if.hi, 32'd0);
    chk("abort_lo", md_if.lo, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("abort_no_late_busy", {31'd0, md_if.busy}, 32'd0);
    chk("abort_no_late_hi", md_if.hi, 32'd0);
    chk("abort_no_late_lo", md_if.lo, 32'd0);

    // Accumulate ops
    issue(4'd6, 32'd5, 32'd0);
    chk("madd_pre_lo", md_if.lo, 32'd5);
    issue(4'd7, 32'd2, 32'd3);
`ifdef MD_MADD_EN
    count_busy(n);
    chk("madd_busy_cycles", 32'(n), 32'd5);
    chk("madd_lo", md_if.lo, 32'd11);
    chk("madd_hi", md_if.hi, 32'd0);
    issue(4'd10, 32'd1, 32'd12);
    count_busy(n);
    chk("msubu_busy_cycles", 32'(n), 32'd5);
    chk("msubu_hi", md_if.hi, 32'hFFFF_FFFF);
    chk("msubu_lo", md_if.lo, 32'hFFFF_FFFF);
`else
    chk("madd_off_busy", {31'd0, md_if.busy}, 32'd0);
    for (int i = 0; i < 6; i++) step();
    chk("madd_off_lo", md_if.lo, 32'd5);
    chk("madd_off_hi", md_if.hi, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
